// File: rtl/axi_slice_pkg.sv
// Shared types for the AXI-stream skid slice: per-stage occupancy state.
package axi_slice_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/axi_skid_stage.sv
// One skid stage: main + skid register, fully registered valid/ready.
module axi_skid_stage
    import axi_slice_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] main_q, skid_q;
    logic         ready_q;
    logic         in_xfer, out_xfer;

    // A beat offered while flushing is dropped, so it never counts as a transfer.
    assign in_xfer  = in_valid && ready_q && !flush;
    assign out_xfer = (state_q != ST_EMPTY) && out_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_xfer) state_d = ST_ONE;
                ST_ONE: begin
                    if (in_xfer && !out_xfer)      state_d = ST_TWO;
                    else if (!in_xfer && out_xfer) state_d = ST_EMPTY;
                end
                ST_TWO:   if (out_xfer) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            case (state_q)
                ST_EMPTY: if (in_xfer) main_q <= in_data;
                ST_ONE: begin
                    if (in_xfer && out_xfer) main_q <= in_data;
                    else if (in_xfer)        skid_q <= in_data;
                end
                ST_TWO:   if (out_xfer) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = ready_q;
        out_valid = (state_q != ST_EMPTY);
        out_data  = main_q;
    end

endmodule

// File: rtl/axi_skid_pipeline.sv
// Cascade of DEPTH skid stages carrying {last,data}, with a single occupancy counter.
module axi_skid_pipeline
    import axi_slice_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = $clog2(2*DEPTH+1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  s_axi_valid,
    output logic                  s_axi_ready,
    input  logic [DATA_WIDTH-1:0] s_axi_data,
    input  logic                  s_axi_last,
    output logic                  m_axi_valid,
    input  logic                  m_axi_ready,
    output logic [DATA_WIDTH-1:0] m_axi_data,
    output logic                  m_axi_last,
    output logic [CNT_W-1:0]      occupancy
);

    localparam int PW = DATA_WIDTH + 1;

    logic [DEPTH:0][PW-1:0] chain_data;
    logic [DEPTH:0]         chain_valid;
    logic [DEPTH:0]         chain_ready;
    logic                   in_xfer, out_xfer;
    logic [CNT_W-1:0]       occ_q;

    assign chain_valid[0]            = s_axi_valid;
    assign chain_data[0]             = {s_axi_last, s_axi_data};
    assign s_axi_ready               = chain_ready[0];
    assign m_axi_valid               = chain_valid[DEPTH];
    assign chain_ready[DEPTH]        = m_axi_ready;
    assign {m_axi_last, m_axi_data}  = chain_data[DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        axi_skid_stage #(.W(PW)) u_stage (
            .clk       (clk),
            .resetn    (resetn),
            .flush     (flush),
            .in_valid  (chain_valid[g]),
            .in_ready  (chain_ready[g]),
            .in_data   (chain_data[g]),
            .out_valid (chain_valid[g+1]),
            .out_ready (chain_ready[g+1]),
            .out_data  (chain_data[g+1])
        );
    end

    assign in_xfer  = s_axi_valid && s_axi_ready && !flush;
    assign out_xfer = m_axi_valid && m_axi_ready;

    // Bounded by stage capacity: in_xfer is impossible at 2*DEPTH, out_xfer at 0.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            occ_q <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   occ_q <= occ_q + CNT_W'(1);
                2'b01:   occ_q <= occ_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_axi_skid_pipeline.sv
// Scenario bench for axi_skid_pipeline: handshake recorder plus acceptance-order scoreboard.
module tb_axi_skid_pipeline;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(2*DEPTH+1);

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             flush = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [DW-1:0]    s_data = '0;
    logic             s_last = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [DW-1:0]    m_data;
    logic             m_last;
    logic [CNT_W-1:0] occ;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_skid_pipeline #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .s_axi_valid (s_valid),
        .s_axi_ready (s_ready),
        .s_axi_data  (s_data),
        .s_axi_last  (s_last),
        .m_axi_valid (m_valid),
        .m_axi_ready (m_ready),
        .m_axi_data  (m_data),
        .m_axi_last  (m_last),
        .occupancy   (occ)
    );

    // Recorder: logs every handshake and tracks what occupancy should be as a beat count.
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [DW:0] acc_q[$], got_q[$];
    int          acc_cyc[$], got_cyc[$];
    int          model_occ = 0, occ_mism = 0, occ_max = 0, stab_bad = 0;
    bit          prev_stall = 1'b0;
    logic [DW:0] prev_beat = '0;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (occ !== CNT_W'(model_occ)) occ_mism++;
            if (int'(occ) > occ_max) occ_max = int'(occ);
            if (prev_stall && (!m_valid || {m_last, m_data} !== prev_beat)) stab_bad++;
            prev_stall = resetn && !flush && m_valid && !m_ready;
            prev_beat  = {m_last, m_data};
            if (resetn && !flush && s_valid && s_ready) begin
                acc_q.push_back({s_last, s_data});
                acc_cyc.push_back(cyc);
            end
            if (resetn && m_valid && m_ready) begin
                got_q.push_back({m_last, m_data});
                got_cyc.push_back(cyc);
            end
            if (!resetn || flush) model_occ = 0;
            else model_occ += int'(resetn && s_valid && s_ready) - int'(m_valid && m_ready);
        end
    end

    task automatic clear_logs();
        acc_q.delete(); got_q.delete(); acc_cyc.delete(); got_cyc.delete();
    endtask

    // Offer one beat and hold it until accepted, bounded to 50 cycles.
    task automatic send(input logic [DW:0] beat, output bit ok);
        bit hs;
        ok = 1'b0;
        s_valid = 1'b1;
        {s_last, s_data} = beat;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            hs = s_ready;
            @(posedge clk); #1;
            if (hs) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; s_valid = 1'b1; s_data = 32'h55; m_ready = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (m_valid !== 1'b0 || s_ready !== 1'b0 || occ !== '0 || m_data !== '0 || m_last !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold: m_valid=%b s_ready=%b occ=%0d data=%h last=%b, required all zero",
                         m_valid, s_ready, occ, m_data, m_last);
            end
            @(posedge clk); #1;
        end
        resetn = 1'b1; s_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || occ !== '0) begin
            fails++;
            $display("FAIL reset_release: s_ready=%b m_valid=%b occ=%0d, required 1/0/0", s_ready, m_valid, occ);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        bit ok;
        int to = 0;
        logic [DW:0] exp;
        clear_logs();
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            send({(i == 16), DW'(i)}, ok);
            if (!ok) to++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        tests++;
        if (to != 0 || got_q.size() != 16) begin
            fails++;
            $display("FAIL stream_count: got %0d beats (%0d timeouts), required 16", got_q.size(), to);
        end else begin
            for (int i = 0; i < 16; i++) begin
                exp = {(i == 15), DW'(i + 1)};
                tests++;
                if (got_q[i] !== exp) begin
                    fails++;
                    $display("FAIL stream_beat[%0d]: got %h, required %h", i, got_q[i], exp);
                end
            end
            tests++;
            if (got_cyc[0] - acc_cyc[0] != DEPTH) begin
                fails++;
                $display("FAIL stream_latency: got %0d cycles, required %0d", got_cyc[0] - acc_cyc[0], DEPTH);
            end
            tests++;
            if (got_cyc[15] - got_cyc[0] != 15 || acc_cyc[15] - acc_cyc[0] != 15) begin
                fails++;
                $display("FAIL stream_bubbles: out span %0d in span %0d, required 15/15",
                         got_cyc[15] - got_cyc[0], acc_cyc[15] - acc_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit hs;
        int k = 0;
        clear_logs();
        m_ready = 1'b0; s_valid = 1'b1; s_last = 1'b0; s_data = 32'h100;
        repeat (10) begin
            @(negedge clk);
            hs = s_ready;
            @(posedge clk); #1;
            if (hs) begin
                k++;
                s_data = 32'h100 + DW'(k);
            end
        end
        s_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (k != 2*DEPTH || acc_q.size() != 2*DEPTH) begin
            fails++;
            $display("FAIL bp_accepted: got %0d beats, required %0d", k, 2*DEPTH);
        end
        tests++;
        if (occ !== CNT_W'(2*DEPTH) || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_full: occ=%0d s_ready=%b, required %0d/0", occ, s_ready, 2*DEPTH);
        end
        tests++;
        if (m_valid !== 1'b1 || m_data !== 32'h100) begin
            fails++;
            $display("FAIL bp_head: m_valid=%b data=%h, required 1/00000100", m_valid, m_data);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        tests++;
        if (got_q.size() != 4) begin
            fails++;
            $display("FAIL bp_drain_count: got %0d, required 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (got_q[i] !== {1'b0, 32'h100 + DW'(i)}) begin
                    fails++;
                    $display("FAIL bp_drain[%0d]: got %h, required %h", i, got_q[i], {1'b0, 32'h100 + DW'(i)});
                end
            end
        end
        tests++;
        if (occ !== '0) begin
            fails++;
            $display("FAIL bp_empty_occ: got %0d, required 0", occ);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        bit ok;
        int seen = 0;
        clear_logs();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) send({1'b0, 32'h200 + DW'(i)}, ok);
        flush = 1'b1; s_valid = 1'b1; s_data = 32'hDEADBEEF; s_last = 1'b1;
        @(negedge clk);
        tests++;
        if (occ !== CNT_W'(3)) begin
            fails++;
            $display("FAIL flush_pre_occ: got %0d, required 3", occ);
        end
        @(posedge clk); #1;
        flush = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        tests++;
        if (occ !== '0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_post: occ=%0d m_valid=%b s_ready=%b, required 0/0/1", occ, m_valid, s_ready);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        foreach (got_q[i]) if (got_q[i][DW-1:0] == 32'hDEADBEEF) seen++;
        tests++;
        if (got_q.size() != 0 || seen != 0) begin
            fails++;
            $display("FAIL flush_discard: %0d beats out (%0d DEADBEEF), required 0", got_q.size(), seen);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit hs, hs_prev = 1'b0;
        int bad = 0;
        clear_logs();
        occ_max = 0; stab_bad = 0;
        s_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            m_ready = (c % 11 != 10);
            if (!s_valid || hs_prev) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = $urandom;
                s_last  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            hs_prev = hs;
        end
        s_valid = 1'b0; m_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        tests++;
        if (got_q.size() != acc_q.size() || acc_q.size() == 0) begin
            fails++;
            $display("FAIL rand_count: out %0d, in %0d", got_q.size(), acc_q.size());
        end else begin
            foreach (acc_q[i]) if (got_q[i] !== acc_q[i]) bad++;
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL rand_order: %0d beats differ from acceptance order, required 0", bad);
            end
        end
        tests++;
        if (occ_max > 2*DEPTH) begin
            fails++;
            $display("FAIL rand_occ_max: got %0d, required <= %0d", occ_max, 2*DEPTH);
        end
        tests++;
        if (stab_bad != 0) begin
            fails++;
            $display("FAIL rand_stall_stable: %0d violations, required 0", stab_bad);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        bit ok;
        int to = 0;
        clear_logs();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h300; s_last = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        tests++;
        if (occ !== CNT_W'(2*DEPTH)) begin
            fails++;
            $display("FAIL rst_fill_occ: got %0d, required %0d", occ, 2*DEPTH);
        end
        @(posedge clk); #1;
        resetn = 1'b0; flush = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (occ !== '0 || m_valid !== 1'b0 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid: occ=%0d m_valid=%b s_ready=%b, required 0/0/0", occ, m_valid, s_ready);
        end
        @(posedge clk); #1;
        resetn = 1'b1; flush = 1'b0; s_valid = 1'b0;
        clear_logs();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send({(i == 3), 32'hA0 + DW'(i)}, ok);
            if (!ok) to++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        tests++;
        if (to != 0 || got_q.size() != 4) begin
            fails++;
            $display("FAIL rst_restream_count: got %0d (%0d timeouts), required 4", got_q.size(), to);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (got_q[i] !== {(i == 3), 32'hA0 + DW'(i)}) begin
                    fails++;
                    $display("FAIL rst_restream[%0d]: got %h, required %h", i, got_q[i], {(i == 3), 32'hA0 + DW'(i)});
                end
            end
        end
        tests++;
        if (occ_mism != 0) begin
            fails++;
            $display("FAIL occ_tracking: %0d cycles where occupancy differed from beats held", occ_mism);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
